// File: rtl/pkt_read_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_read_arbiter_if
//  Description : Bundle of signals between the network_tx read controllers,
//                pkt_read_arbiter and the central buffer memory read port.
//                slave  - the arbiter's view
//                master - the surrounding requesters/memory's view
//  Ports       : iv_pkt_raddr/iv_pkt_rd/ov_pkt_raddr_ack : request side
//                ov_mem_raddr/o_mem_rd                    : memory read strobe
//                iv_mem_data/i_mem_data_wr                : memory return
//                ov_pkt_data/ov_pkt_data_wr               : steered return
//                o_unexp_data_pulse/ov_rr_ptr             : status
//  Revision    : 1.0 - initial release
// ============================================================================
interface pkt_read_arbiter_if #(
  parameter int N_PORT = 4
);
  logic [16*N_PORT-1:0] iv_pkt_raddr;
  logic [N_PORT-1:0]    iv_pkt_rd;
  logic [N_PORT-1:0]    ov_pkt_raddr_ack;
  logic [15:0]          ov_mem_raddr;
  logic                 o_mem_rd;
  logic [133:0]         iv_mem_data;
  logic                 i_mem_data_wr;
  logic [133:0]         ov_pkt_data;
  logic [N_PORT-1:0]    ov_pkt_data_wr;
  logic                 o_unexp_data_pulse;
  logic [2:0]           ov_rr_ptr;

  modport slave (
    input  iv_pkt_raddr, iv_pkt_rd, iv_mem_data, i_mem_data_wr,
    output ov_pkt_raddr_ack, ov_mem_raddr, o_mem_rd,
    output ov_pkt_data, ov_pkt_data_wr, o_unexp_data_pulse, ov_rr_ptr
  );

  modport master (
    output iv_pkt_raddr, iv_pkt_rd, iv_mem_data, i_mem_data_wr,
    input  ov_pkt_raddr_ack, ov_mem_raddr, o_mem_rd,
    input  ov_pkt_data, ov_pkt_data_wr, o_unexp_data_pulse, ov_rr_ptr
  );
endinterface
`default_nettype wire

// File: rtl/pkt_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_read_arbiter
//  Description : Round-robin arbiter sharing the single read port of the
//                central buffer memory among N_PORT read controllers. One
//                read is granted per cycle; each issued read is tagged with
//                its port and the tag travels RD_LAT stages so the returned
//                line is steered back to the port that asked for it.
//  Ports       : i_clk  - core clock (125 MHz)
//                i_rst  - synchronous active-high reset
//                bus    - pkt_read_arbiter_if.slave (requests, memory strobe,
//                         memory return, steered data, status)
//  Parameters  : N_PORT - requesting ports, 2..8
//                RD_LAT - memory read latency in cycles, 1..4
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_read_arbiter #(
  parameter int N_PORT = 4,
  parameter int RD_LAT = 2
) (
  input wire                 i_clk,
  input wire                 i_rst,
  pkt_read_arbiter_if.slave  bus
);

  // Grant register
  logic [N_PORT-1:0]   r_ack;
  logic                r_mem_rd;
  logic [15:0]         r_mem_raddr;
  logic [2:0]          r_gnt_idx;
  logic [2:0]          r_rr_ptr;

  // Tag pipeline, stage RD_LAT-1 lines up with i_mem_data_wr
  logic                r_tag_v   [RD_LAT];
  logic [2:0]          r_tag_idx [RD_LAT];

  // Return path
  logic [133:0]        r_pkt_data;
  logic [N_PORT-1:0]   r_pkt_data_wr;
  logic                r_unexp;

  logic [N_PORT-1:0]   w_elig;
  logic [N_PORT-1:0]   w_rot;
  logic                w_found;
  logic [2:0]          w_off;
  logic [3:0]          w_sum;
  logic [2:0]          w_win;
  logic [2:0]          w_ptr_nxt;
  logic [15:0]         w_win_addr;
  logic                w_tail_v;
  logic [2:0]          w_tail_idx;
  logic                w_ret_hit;

  // A port acked this cycle still has rd high; masking it avoids a re-grant
  // of the same request before the requester has had a chance to drop rd.
  assign w_elig = bus.iv_pkt_rd & ~r_ack;

  // Rotate so that bit 0 is the port at rr_ptr; the lowest set bit of the
  // rotated vector is then the round-robin winner's offset from rr_ptr.
  assign w_rot = N_PORT'({w_elig, w_elig} >> r_rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = 3'd0;
    for (int i = N_PORT - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = 3'(i);
      end
    end
  end

  // Undo the rotation: (rr_ptr + offset) mod N_PORT
  assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_win     = (w_sum >= 4'(N_PORT)) ? 3'(w_sum - 4'(N_PORT)) : w_sum[2:0];
  assign w_ptr_nxt = (w_win == 3'(N_PORT - 1)) ? 3'd0 : w_win + 3'd1;

  always_comb begin
    w_win_addr = 16'd0;
    for (int i = 0; i < N_PORT; i++) begin
      if (w_win == 3'(i)) begin
        w_win_addr = bus.iv_pkt_raddr[16*i +: 16];
      end
    end
  end

  assign w_tail_v   = r_tag_v[RD_LAT-1];
  assign w_tail_idx = r_tag_idx[RD_LAT-1];
  assign w_ret_hit  = bus.i_mem_data_wr & w_tail_v;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack         <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_raddr   <= 16'd0;
      r_gnt_idx     <= 3'd0;
      r_rr_ptr      <= 3'd0;
      for (int s = 0; s < RD_LAT; s++) begin
        r_tag_v[s]   <= 1'b0;
        r_tag_idx[s] <= 3'd0;
      end
      r_pkt_data    <= '0;
      r_pkt_data_wr <= '0;
      r_unexp       <= 1'b0;
    end else begin
      r_mem_rd <= w_found;
      r_ack    <= w_found ? (N_PORT'(1) << w_win) : '0;
      if (w_found) begin
        r_mem_raddr <= w_win_addr;
        r_gnt_idx   <= w_win;
        r_rr_ptr    <= w_ptr_nxt;
      end

      // The read on the memory strobe this cycle enters the tag pipeline
      r_tag_v[0]   <= r_mem_rd;
      r_tag_idx[0] <= r_gnt_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        r_tag_v[s]   <= r_tag_v[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end

      // A valid tail without returning data is simply shifted out.
      r_pkt_data_wr <= w_ret_hit ? (N_PORT'(1) << w_tail_idx) : '0;
      if (w_ret_hit) begin
        r_pkt_data <= bus.iv_mem_data;
      end
      r_unexp <= bus.i_mem_data_wr & ~w_tail_v;
    end
  end

  assign bus.ov_pkt_raddr_ack   = r_ack;
  assign bus.o_mem_rd           = r_mem_rd;
  assign bus.ov_mem_raddr       = r_mem_raddr;
  assign bus.ov_pkt_data        = r_pkt_data;
  assign bus.ov_pkt_data_wr     = r_pkt_data_wr;
  assign bus.o_unexp_data_pulse = r_unexp;
  assign bus.ov_rr_ptr          = r_rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_pkt_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkt_read_arbiter
//  Description : Self-checking bench for pkt_read_arbiter. A memory model
//                answers each strobe RD_LAT cycles later; a transaction-level
//                reference model (round-robin search plus a queue of reads
//                with due cycles) predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_read_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  pkt_read_arbiter_if #(.N_PORT(N)) dut_if ();

  pkt_read_arbiter #(.N_PORT(N), .RD_LAT(LAT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (dut_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory model: pending returns
  typedef struct { int due; logic [133:0] data; } mem_ret_t;
  mem_ret_t mem_q[$];
  logic     inj_unexp = 1'b0;

  // Reference model state: outputs of the current cycle + reads in flight
  typedef struct { int due; int port; } fly_t;
  fly_t         m_fly[$];
  logic [N-1:0] m_ack, m_wr;
  logic         m_rd, m_unexp;
  logic [15:0]  m_addr;
  logic [133:0] m_data;
  int           m_ptr, m_port;

  function automatic logic [133:0] mem_line(input logic [15:0] a);
    return {2'b11, 100'd0, a, 16'h0ABC};
  endfunction

  task automatic set_addr(input int k, input logic [15:0] a);
    logic [16*N-1:0] v;
    v = dut_if.iv_pkt_raddr;
    v[16*k +: 16] = a;
    dut_if.iv_pkt_raddr = v;
  endtask

  task automatic model_edge();
    logic [N-1:0] elig;
    bit hit;
    int hit_port, w, p;
    if (rst) begin
      m_ack = '0; m_rd = 1'b0; m_addr = '0; m_data = '0; m_wr = '0;
      m_unexp = 1'b0; m_ptr = 0; m_port = 0;
      m_fly.delete();
      return;
    end
    hit = 1'b0; hit_port = 0;
    while (m_fly.size() > 0 && m_fly[0].due <= cyc) begin
      if (m_fly[0].due == cyc) begin hit = 1'b1; hit_port = m_fly[0].port; end
      m_fly.delete(0);
    end
    m_wr = '0; m_unexp = 1'b0;
    if (dut_if.i_mem_data_wr) begin
      if (hit) begin m_wr = 4'(1) << hit_port; m_data = dut_if.iv_mem_data; end
      else m_unexp = 1'b1;
    end
    if (m_rd) m_fly.push_back('{due: cyc + LAT, port: m_port});
    elig = dut_if.iv_pkt_rd & ~m_ack;
    w = -1;
    for (int i = 0; i < N; i++) begin
      p = (m_ptr + i) % N;
      if (w < 0 && (elig & (4'(1) << p)) != '0) w = p;
    end
    if (w >= 0) begin
      m_ack = 4'(1) << w; m_rd = 1'b1; m_port = w; m_ptr = (w + 1) % N;
      m_addr = 16'(dut_if.iv_pkt_raddr >> (16 * w));
    end else begin
      m_ack = '0; m_rd = 1'b0;
    end
  endtask

  // One clock: memory reacts to the current cycle, then edge, then sample.
  task automatic step();
    if (dut_if.o_mem_rd === 1'b1)
      mem_q.push_back('{due: cyc + LAT, data: mem_line(dut_if.ov_mem_raddr)});
    dut_if.i_mem_data_wr = 1'b0;
    dut_if.iv_mem_data   = 134'({$urandom, $urandom, $urandom, $urandom, $urandom});
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      dut_if.i_mem_data_wr = 1'b1;
      dut_if.iv_mem_data   = mem_q[0].data;
      mem_q.delete(0);
    end else if (inj_unexp) begin
      dut_if.i_mem_data_wr = 1'b1;
    end
    inj_unexp = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    dut_if.iv_pkt_rd = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    dut_if.iv_pkt_rd = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    dut_if.iv_pkt_rd = '0;
    rst = 1'b1;
    step(); step();
    checks++; if (dut_if.ov_pkt_raddr_ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %h want 0", dut_if.ov_pkt_raddr_ack); end
    checks++; if (dut_if.o_mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", dut_if.o_mem_rd); end
    checks++; if (dut_if.ov_mem_raddr !== 16'h0) begin errors++; $display("FAIL reset_raddr: got %h want 0", dut_if.ov_mem_raddr); end
    checks++; if (dut_if.ov_pkt_data !== 134'h0) begin errors++; $display("FAIL reset_data: got %h want 0", dut_if.ov_pkt_data); end
    checks++; if (dut_if.ov_pkt_data_wr !== 4'h0) begin errors++; $display("FAIL reset_data_wr: got %h want 0", dut_if.ov_pkt_data_wr); end
    checks++; if (dut_if.o_unexp_data_pulse !== 1'b0) begin errors++; $display("FAIL reset_unexp: got %b want 0", dut_if.o_unexp_data_pulse); end
    checks++; if (dut_if.ov_rr_ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", dut_if.ov_rr_ptr); end
    rst = 1'b0;
  endtask

  task automatic test_single_port();
    set_addr(2, 16'h0123);
    dut_if.iv_pkt_rd = 4'b0100;
    step();
    checks++; if (dut_if.ov_pkt_raddr_ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", dut_if.ov_pkt_raddr_ack); end
    checks++; if (dut_if.o_mem_rd !== 1'b1) begin errors++; $display("FAIL single_mem_rd: got %b want 1", dut_if.o_mem_rd); end
    checks++; if (dut_if.ov_mem_raddr !== 16'h0123) begin errors++; $display("FAIL single_raddr: got %h want 0123", dut_if.ov_mem_raddr); end
    checks++; if (dut_if.ov_rr_ptr !== 3'd3) begin errors++; $display("FAIL single_ptr: got %0d want 3", dut_if.ov_rr_ptr); end
    step();
    dut_if.iv_pkt_rd = '0;
    step(); step();
    checks++; if (dut_if.ov_pkt_data_wr !== 4'b0100) begin errors++; $display("FAIL single_data_wr: got %b want 0100", dut_if.ov_pkt_data_wr); end
    checks++; if (dut_if.ov_pkt_data !== {2'b11, 100'd0, 16'h0123, 16'h0ABC}) begin errors++; $display("FAIL single_data: got %h want 3..01230abc", dut_if.ov_pkt_data); end
    step();
    checks++; if (dut_if.ov_pkt_data_wr !== 4'b0000) begin errors++; $display("FAIL single_data_wr_pulse: got %b want 0000", dut_if.ov_pkt_data_wr); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] old, seen;
    do_reset();
    for (int k = 0; k < N; k++) set_addr(k, 16'h0010 + 16'(k));
    dut_if.iv_pkt_rd = 4'hF;
    old = '0; seen = '0;
    for (int k = 1; k <= 8; k++) begin
      dut_if.iv_pkt_rd = dut_if.iv_pkt_rd & ~old;
      old = seen;
      step();
      seen = dut_if.ov_pkt_raddr_ack;
      if (k <= 4) begin
        checks++; if (seen !== 4'(1) << (k - 1)) begin errors++; $display("FAIL rr_ack k=%0d: got %b want %b", k, seen, 4'(1) << (k - 1)); end
        checks++; if (dut_if.ov_mem_raddr !== 16'h0010 + 16'(k - 1)) begin errors++; $display("FAIL rr_raddr k=%0d: got %h", k, dut_if.ov_mem_raddr); end
      end
      if (k >= 4 && k <= 7) begin
        checks++; if (dut_if.ov_pkt_data_wr !== 4'(1) << (k - 4)) begin errors++; $display("FAIL rr_data_wr k=%0d: got %b want %b", k, dut_if.ov_pkt_data_wr, 4'(1) << (k - 4)); end
        checks++; if (dut_if.ov_pkt_data !== mem_line(16'h0010 + 16'(k - 4))) begin errors++; $display("FAIL rr_data k=%0d: got %h", k, dut_if.ov_pkt_data); end
      end
    end
    idle(4);
  endtask

  task automatic test_ack_mask();
    logic want;
    set_addr(0, 16'h0500);
    for (int k = 1; k <= 7; k++) begin
      dut_if.iv_pkt_rd = (k <= 6) ? 4'b0001 : 4'b0000;
      step();
      want = (k == 1 || k == 3 || k == 5);
      checks++; if (dut_if.ov_pkt_raddr_ack !== {3'b000, want}) begin errors++; $display("FAIL mask_ack k=%0d: got %b want %b", k, dut_if.ov_pkt_raddr_ack, {3'b000, want}); end
      checks++; if (dut_if.o_mem_rd !== want) begin errors++; $display("FAIL mask_mem_rd k=%0d: got %b want %b", k, dut_if.o_mem_rd, want); end
    end
    idle(4);
  endtask

  task automatic test_pointer_update();
    logic [N-1:0] old, seen;
    do_reset();
    set_addr(1, 16'h0100);
    dut_if.iv_pkt_rd = 4'b0010;
    step(); step();
    idle(4);
    checks++; if (dut_if.ov_rr_ptr !== 3'd2) begin errors++; $display("FAIL ptr_setup: got %0d want 2", dut_if.ov_rr_ptr); end
    set_addr(1, 16'h0201);
    set_addr(3, 16'h0203);
    dut_if.iv_pkt_rd = 4'b1010;
    old = '0; seen = '0;
    for (int k = 1; k <= 4; k++) begin
      dut_if.iv_pkt_rd = dut_if.iv_pkt_rd & ~old;
      old = seen;
      step();
      seen = dut_if.ov_pkt_raddr_ack;
      if (k == 1) begin
        checks++; if (seen !== 4'b1000) begin errors++; $display("FAIL ptr_first: got %b want 1000", seen); end
        checks++; if (dut_if.ov_mem_raddr !== 16'h0203) begin errors++; $display("FAIL ptr_first_addr: got %h want 0203", dut_if.ov_mem_raddr); end
        checks++; if (dut_if.ov_rr_ptr !== 3'd0) begin errors++; $display("FAIL ptr_after_first: got %0d want 0", dut_if.ov_rr_ptr); end
      end
      if (k == 2) begin
        checks++; if (seen !== 4'b0010) begin errors++; $display("FAIL ptr_second: got %b want 0010", seen); end
        checks++; if (dut_if.ov_rr_ptr !== 3'd2) begin errors++; $display("FAIL ptr_after_second: got %0d want 2", dut_if.ov_rr_ptr); end
      end
    end
    idle(4);
  endtask

  task automatic test_unexpected();
    idle(2);
    inj_unexp = 1'b1;
    step();
    checks++; if (dut_if.o_unexp_data_pulse !== 1'b1) begin errors++; $display("FAIL unexp_pulse: got %b want 1", dut_if.o_unexp_data_pulse); end
    checks++; if (dut_if.ov_pkt_data_wr !== 4'h0) begin errors++; $display("FAIL unexp_data_wr: got %b want 0000", dut_if.ov_pkt_data_wr); end
    step();
    checks++; if (dut_if.o_unexp_data_pulse !== 1'b0) begin errors++; $display("FAIL unexp_one_cycle: got %b want 0", dut_if.o_unexp_data_pulse); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_addr(1, 16'h0AAA);
    dut_if.iv_pkt_rd = 4'b0010;
    step();
    checks++; if (dut_if.o_mem_rd !== 1'b1) begin errors++; $display("FAIL mid_strobe: got %b want 1", dut_if.o_mem_rd); end
    step();
    dut_if.iv_pkt_rd = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (dut_if.ov_pkt_raddr_ack !== 4'h0 || dut_if.o_mem_rd !== 1'b0 || dut_if.ov_mem_raddr !== 16'h0)
      begin errors++; $display("FAIL mid_grant_cleared: ack %b rd %b addr %h want all 0", dut_if.ov_pkt_raddr_ack, dut_if.o_mem_rd, dut_if.ov_mem_raddr); end
    checks++; if (dut_if.ov_pkt_data !== 134'h0 || dut_if.ov_pkt_data_wr !== 4'h0 || dut_if.o_unexp_data_pulse !== 1'b0)
      begin errors++; $display("FAIL mid_return_cleared: data_wr %b unexp %b data %h want all 0", dut_if.ov_pkt_data_wr, dut_if.o_unexp_data_pulse, dut_if.ov_pkt_data); end
    step();
    checks++; if (dut_if.o_unexp_data_pulse !== 1'b1) begin errors++; $display("FAIL mid_stale_unexp: got %b want 1", dut_if.o_unexp_data_pulse); end
    checks++; if (dut_if.ov_pkt_data_wr !== 4'h0) begin errors++; $display("FAIL mid_stale_data_wr: got %b want 0000", dut_if.ov_pkt_data_wr); end
    checks++; if (dut_if.ov_rr_ptr !== 3'd0) begin errors++; $display("FAIL mid_ptr: got %0d want 0", dut_if.ov_rr_ptr); end
    idle(3);
  endtask

  task automatic test_random();
    logic [N-1:0] old, seen, rd;
    do_reset();
    old = '0; seen = '0;
    for (int c = 0; c < 460; c++) begin
      rd = dut_if.iv_pkt_rd;
      for (int k = 0; k < N; k++) begin
        if (c >= 450) rd[k] = 1'b0;
        else if (old[k]) begin
          if ($urandom_range(1, 0) == 0) rd[k] = 1'b0;
          else set_addr(k, 16'($urandom));
        end else if (!rd[k] && $urandom_range(2, 0) == 0) begin
          rd[k] = 1'b1;
          set_addr(k, 16'($urandom));
        end
      end
      dut_if.iv_pkt_rd = rd;
      if (mem_q.size() == 0 && $urandom_range(15, 0) == 0) inj_unexp = 1'b1;
      old = seen;
      step();
      seen = dut_if.ov_pkt_raddr_ack;
      checks++; if (dut_if.ov_pkt_raddr_ack !== m_ack) begin errors++; $display("FAIL rand_ack cyc=%0d: got %b want %b", cyc, dut_if.ov_pkt_raddr_ack, m_ack); end
      checks++; if (dut_if.o_mem_rd !== m_rd) begin errors++; $display("FAIL rand_mem_rd cyc=%0d: got %b want %b", cyc, dut_if.o_mem_rd, m_rd); end
      if (m_rd) begin
        checks++; if (dut_if.ov_mem_raddr !== m_addr) begin errors++; $display("FAIL rand_raddr cyc=%0d: got %h want %h", cyc, dut_if.ov_mem_raddr, m_addr); end
      end
      checks++; if (dut_if.ov_pkt_data_wr !== m_wr) begin errors++; $display("FAIL rand_data_wr cyc=%0d: got %b want %b", cyc, dut_if.ov_pkt_data_wr, m_wr); end
      checks++; if (dut_if.ov_pkt_data !== m_data) begin errors++; $display("FAIL rand_data cyc=%0d: got %h want %h", cyc, dut_if.ov_pkt_data, m_data); end
      checks++; if (dut_if.o_unexp_data_pulse !== m_unexp) begin errors++; $display("FAIL rand_unexp cyc=%0d: got %b want %b", cyc, dut_if.o_unexp_data_pulse, m_unexp); end
      checks++; if (dut_if.ov_rr_ptr !== 3'(m_ptr)) begin errors++; $display("FAIL rand_ptr cyc=%0d: got %0d want %0d", cyc, dut_if.ov_rr_ptr, m_ptr); end
    end
  endtask

  initial begin
    rst                  = 1'b1;
    dut_if.iv_pkt_rd     = '0;
    dut_if.iv_pkt_raddr  = '0;
    dut_if.iv_mem_data   = '0;
    dut_if.i_mem_data_wr = 1'b0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_ack_mask();
    test_pointer_update();
    test_unexpected();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pkt_read_arbiter.md
# pkt_read_arbiter

Shares the single read port of pkt_centralize_bufm_memory among the N_PORT network_tx read controllers. It grants one read address per cycle with round-robin fairness and acknowledges the winning port. It tracks each issued read through the fixed memory read latency and steers the returned 134-bit line back to the port that requested it. It sits between the per-port network_tx instances and the central buffer memory, all in the 125 MHz core domain.

## Interface
- N_PORT, 4: number of requesting ports, 2..8.
- RD_LAT, 2: cycles from o_mem_rd to i_mem_data_wr, fixed by the memory, 1..4.
- i_clk  in  1  core clock, 125 MHz; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- iv_pkt_raddr  in  16*N_PORT  per-port read address; port k uses bits [16k+15:16k].
- iv_pkt_rd  in  N_PORT  per-port read request; held with a stable address until acked.
- ov_pkt_raddr_ack  out  N_PORT  one-cycle ack pulse to the granted port.
- ov_mem_raddr  out  16  address to the memory.
- o_mem_rd  out  1  read strobe to the memory; one line per strobe.
- iv_mem_data  in  134  returned line from the memory.
- i_mem_data_wr  in  1  returned line valid.
- ov_pkt_data  out  134  returned line, shared by all ports.
- ov_pkt_data_wr  out  N_PORT  one-hot valid for the owning port.
- o_unexp_data_pulse  out  1  pulse when returned data has no pending read.
- ov_rr_ptr  out  3  current round-robin pointer, for status.

## Operation
- Eligibility: eligible[k] = iv_pkt_rd[k] & ~ov_pkt_raddr_ack[k].
  - The port being acked this cycle is masked.
  - This masking stops a re-grant while the requester is still dropping rd.
- Arbitration: round-robin starting at rr_ptr.
  - The winner is the first eligible port at index rr_ptr, rr_ptr+1, … mod N_PORT.
  - When there is a winner at index w, rr_ptr is updated to (w+1) mod N_PORT.
  - With no eligible port, rr_ptr is unchanged and no strobe is issued.
- Grant register: on a winner, the next cycle drives:
  - o_mem_rd=1;
  - ov_mem_raddr = the winner's address slice;
  - ov_pkt_raddr_ack[w]=1.
  - All three are registered and asserted in the same cycle.
- Tag pipeline: a shift register of RD_LAT stages, each holding {valid, idx[2:0]}.
  - The stage loaded with {o_mem_rd, w} advances every cycle.
  - Its tail aligns with i_mem_data_wr.
- Return path: when i_mem_data_wr=1 and the tail is valid, the next cycle drives:
  - ov_pkt_data = iv_mem_data;
  - ov_pkt_data_wr = one-hot(tail idx).
- Error cases:
  - i_mem_data_wr=1 with an invalid tail: the data is dropped, ov_pkt_data_wr stays 0, and o_unexp_data_pulse=1 for one cycle.
  - Valid tail with i_mem_data_wr=0: the tag is discarded silently. The memory contract forbids this; no recovery is attempted.
- ov_pkt_data holds its last value when not written.
- Reset clears:
  - the grant register, all tag stages and all outputs;
  - rr_ptr, which is set to 0.
- Reset mid-operation:
  - In-flight reads are forgotten.
  - Returning data after reset release raises o_unexp_data_pulse.
  - Requesters are reset by the same i_rst and do not expect the data.

## Timing
- Reset values: ov_pkt_raddr_ack=0, ov_mem_raddr=0, o_mem_rd=0, ov_pkt_data=0, ov_pkt_data_wr=0, o_unexp_data_pulse=0, ov_rr_ptr=0.
- Request to ack/strobe: 1 cycle.
  - With iv_pkt_rd[k] rising in cycle T and k winning, the ack and o_mem_rd appear in T+1.
- Requester rule:
  - deassert rd, or present the next address, in T+2;
  - never change the address while rd=1 and no ack has been received.
- Throughput:
  - Different ports can be granted back-to-back, one read per cycle.
  - A single continuously requesting port gets at most one read per 2 cycles, because of the ack mask.
- Read return: i_mem_data_wr arrives at T+1+RD_LAT; ov_pkt_data_wr arrives at T+2+RD_LAT.
  - Total request-to-data latency is RD_LAT+2 = 4 cycles at the defaults.
- Fairness: with all N_PORT ports requesting continuously, each port is granted within N_PORT cycles of becoming eligible.
- Simultaneous grant and return are independent: both the grant and the return can complete in the same cycle.

## Test plan
- Single port: port 2 requests addr 0x0123 at T.
  - Expect at T+1: ack[2], o_mem_rd=1, ov_mem_raddr=0x0123.
  - The memory model returns 0x3_0000…0ABC at T+3.
  - Expect at T+4: ov_pkt_data_wr=4'b0100 and ov_pkt_data=0x3_0000…0ABC.
- Round-robin: all 4 ports hold rd with addresses 0x0010..0x0013 from T, with rr_ptr=0.
  - Expect grants 0,1,2,3 on T+1..T+4 with matching addresses.
  - Expect data steered in order on T+4..T+7.
- Ack mask: port 0 alone holds rd for 6 cycles.
  - Expect acks only at T+1, T+3, T+5.
  - No duplicate o_mem_rd while the requester is still dropping rd.
- Pointer update: ports 1 and 3 request with rr_ptr=2.
  - Expect port 3 first, then port 1; rr_ptr goes 0→2 after the grants.
- Unexpected data: i_mem_data_wr=1 with no reads outstanding.
  - Expect o_unexp_data_pulse=1 for one cycle and ov_pkt_data_wr=0.
- Reset mid-flight: assert i_rst one cycle after o_mem_rd for port 1, and let the memory return as normal.
  - Expect all outputs at 0 and no ov_pkt_data_wr[1].
  - Expect o_unexp_data_pulse when the stale data arrives after reset release.
  - Expect ov_rr_ptr=0.
